rf_wb_ctrl: RTL and testbench

Writer side of the integer register file: a writeback controller with a scoreboard.
- Arbitrates completed results from the ALU and LSU over valid/ready handshakes.
- Drives the register file write port (write enable, write address, write data) from a registered stage.
- Tracks destination registers with outstanding writes, so issue logic can stall on RAW/WAW hazards for the two register-file read addresses.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_wb_ctrl_if.sv | 54 +++++
 rtl/rr_arb2.sv | 43 ++++
 rtl/rf_wb_ctrl.sv | 104 ++++++++++
 tb/tb_rf_wb_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file writeback slice.
package rf_pkg;

  localparam int unsigned RF_ADDR_NBW = 5;
  localparam int unsigned RF_DATA_NBW = 32;

  // Which result source won the most recent arbitration.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Issue, result, register-file write and hazard-check signals of the writeback controller.
interface rf_wb_ctrl_if
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_NBW = RF_ADDR_NBW,
  parameter int unsigned DATA_NBW = RF_DATA_NBW
) ();

  logic                i_iss_valid;
  logic [ADDR_NBW-1:0] i_iss_rd;
  logic                o_iss_ready;

  logic                i_alu_valid;
  logic [ADDR_NBW-1:0] i_alu_rd;
  logic [DATA_NBW-1:0] i_alu_dt;
  logic                o_alu_ready;

  logic                i_lsu_valid;
  logic [ADDR_NBW-1:0] i_lsu_rd;
  logic [DATA_NBW-1:0] i_lsu_dt;
  logic                o_lsu_ready;

  logic                o_wr_en;
  logic [ADDR_NBW-1:0] o_wr_addr;
  logic [DATA_NBW-1:0] o_wr_dt;

  logic [ADDR_NBW-1:0] i_rd_addr_1;
  logic [ADDR_NBW-1:0] i_rd_addr_2;
  logic                o_busy_1;
  logic                o_busy_2;

  logic                o_sb_err;

  // Environment side: issue stage, execution units, register file readers.
  modport master (
    output i_iss_valid, i_iss_rd, input o_iss_ready,
    output i_alu_valid, i_alu_rd, i_alu_dt, input o_alu_ready,
    output i_lsu_valid, i_lsu_rd, i_lsu_dt, input o_lsu_ready,
    input  o_wr_en, o_wr_addr, o_wr_dt,
    output i_rd_addr_1, i_rd_addr_2, input o_busy_1, o_busy_2,
    input  o_sb_err
  );

  // Writeback controller side.
  modport slave (
    input  i_iss_valid, i_iss_rd, output o_iss_ready,
    input  i_alu_valid, i_alu_rd, i_alu_dt, output o_alu_ready,
    input  i_lsu_valid, i_lsu_rd, i_lsu_dt, output o_lsu_ready,
    output o_wr_en, o_wr_addr, o_wr_dt,
    input  i_rd_addr_1, i_rd_addr_2, output o_busy_1, o_busy_2,
    output o_sb_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the ALU, bit 1 the LSU.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_async_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  src_e r_last;
  src_e w_last_d;

  // Grant the sole requester, or on a tie the one not granted last.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last == SRC_LSU) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Remember the winner only when a grant is actually taken.
  always_comb begin
    w_last_d = r_last;
    if (i_upd && (o_gnt != 2'b00)) begin
      w_last_d = o_gnt[1] ? SRC_LSU : SRC_ALU;
    end
  end

  // Last-grant flop; reset to LSU so the ALU wins the first tie.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_last <= SRC_LSU;
    end else begin
      r_last <= w_last_d;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register file writeback controller: arbitrates ALU/LSU results into a registered write
// port and keeps a pending-write scoreboard for RAW/WAW hazard checks.
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_NBW = RF_ADDR_NBW,
  parameter int unsigned DATA_NBW = RF_DATA_NBW
) (
  input  logic         clk,
  input  logic         rst_async_n,
  rf_wb_ctrl_if.slave  io_wb
);

  localparam int unsigned Depth = 2 ** ADDR_NBW;

  logic [Depth-1:0]    r_pend;
  logic [Depth-1:0]    w_pend_d;
  logic                r_wr_en;
  logic [ADDR_NBW-1:0] r_wr_addr;
  logic [DATA_NBW-1:0] r_wr_dt;
  logic                r_sb_err;

  logic [1:0]          w_gnt;
  logic                w_any_gnt;
  logic [ADDR_NBW-1:0] w_sel_rd;
  logic [DATA_NBW-1:0] w_sel_dt;
  logic                w_iss_ready;
  logic                w_iss_fire;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .i_req       ({io_wb.i_lsu_valid, io_wb.i_alu_valid}),
    .i_upd       (w_any_gnt),
    .o_gnt       (w_gnt)
  );

  assign w_any_gnt = |w_gnt;

  // Conservative: a clear landing this same cycle does not make the issue ready.
  assign w_iss_ready = (io_wb.i_iss_rd == '0) | ~r_pend[io_wb.i_iss_rd];
  assign w_iss_fire  = io_wb.i_iss_valid & w_iss_ready & (io_wb.i_iss_rd != '0);

  // Select the granted result for the writeback stage.
  always_comb begin
    w_sel_rd = io_wb.i_alu_rd;
    w_sel_dt = io_wb.i_alu_dt;
    if (w_gnt[1]) begin
      w_sel_rd = io_wb.i_lsu_rd;
      w_sel_dt = io_wb.i_lsu_dt;
    end
  end

  // Scoreboard next state: clear on write, then set on issue so set wins a collision.
  always_comb begin
    w_pend_d = r_pend;
    if (r_wr_en) begin
      w_pend_d[r_wr_addr] = 1'b0;
    end
    if (w_iss_fire) begin
      w_pend_d[io_wb.i_iss_rd] = 1'b1;
    end
    w_pend_d[0] = 1'b0;
  end

  // Scoreboard and sticky error flag.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_pend   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_pend <= w_pend_d;
      if (r_wr_en && !r_pend[r_wr_addr]) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  // Writeback stage; rd 0 results are consumed without a write.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_dt   <= '0;
    end else if (w_any_gnt) begin
      r_wr_en   <= (w_sel_rd != '0);
      r_wr_addr <= w_sel_rd;
      r_wr_dt   <= w_sel_dt;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign io_wb.o_iss_ready = w_iss_ready;
  assign io_wb.o_alu_ready = w_gnt[0];
  assign io_wb.o_lsu_ready = w_gnt[1];
  assign io_wb.o_wr_en     = r_wr_en;
  assign io_wb.o_wr_addr   = r_wr_addr;
  assign io_wb.o_wr_dt     = r_wr_dt;
  assign io_wb.o_busy_1    = r_pend[io_wb.i_rd_addr_1];
  assign io_wb.o_busy_2    = r_pend[io_wb.i_rd_addr_2];
  assign io_wb.o_sb_err    = r_sb_err;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: directed stimulus with a queue of expected register-file writes.
module tb_rf_wb_ctrl;

  logic clk;
  logic rst_async_n;

  int unsigned n_checks;
  int unsigned n_errors;

  // Expected write: {addr[7:0], data[31:0]}
  logic [39:0] exp_q[$];

  rf_wb_ctrl_if #(.ADDR_NBW(5), .DATA_NBW(32)) u_if ();

  rf_wb_ctrl #(.ADDR_NBW(5), .DATA_NBW(32)) u_dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .io_wb       (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] addr, input logic [31:0] dt);
    exp_q.push_back({3'b000, addr, dt});
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_async_n && u_if.o_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", {59'd0, u_if.o_wr_addr}, 64'hFFFF);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {59'd0, u_if.o_wr_addr}, {56'd0, e[39:32]});
        chk("wr_dt", {32'd0, u_if.o_wr_dt}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_async_n       = 1'b0;
    u_if.i_iss_valid  = 1'b0;
    u_if.i_iss_rd     = '0;
    u_if.i_alu_valid  = 1'b0;
    u_if.i_alu_rd     = '0;
    u_if.i_alu_dt     = '0;
    u_if.i_lsu_valid  = 1'b0;
    u_if.i_lsu_rd     = '0;
    u_if.i_lsu_dt     = '0;
    u_if.i_rd_addr_1  = '0;
    u_if.i_rd_addr_2  = '0;
    #12;
    rst_async_n = 1'b1;
    cyc();

    // Reset state
    for (int a = 0; a < 32; a++) begin
      u_if.i_rd_addr_1 = 5'(a);
      u_if.i_rd_addr_2 = 5'(31 - a);
      #1;
      chk("rst_busy1", {63'd0, u_if.o_busy_1}, 64'd0);
      chk("rst_busy2", {63'd0, u_if.o_busy_2}, 64'd0);
    end
    chk("rst_wr_en", {63'd0, u_if.o_wr_en}, 64'd0);
    chk("rst_wr_addr", {59'd0, u_if.o_wr_addr}, 64'd0);
    chk("rst_wr_dt", {32'd0, u_if.o_wr_dt}, 64'd0);
    chk("rst_sb_err", {63'd0, u_if.o_sb_err}, 64'd0);
    chk("rst_alu_ready", {63'd0, u_if.o_alu_ready}, 64'd0);

    // Issue rd 5, then ALU writes it back
    cyc();
    u_if.i_iss_valid = 1'b1;
    u_if.i_iss_rd    = 5'd5;
    #1;
    chk("iss5_ready", {63'd0, u_if.o_iss_ready}, 64'd1);
    cyc();
    u_if.i_iss_valid = 1'b0;
    u_if.i_rd_addr_1 = 5'd5;
    #1;
    chk("busy5_set", {63'd0, u_if.o_busy_1}, 64'd1);
    u_if.i_alu_valid = 1'b1;
    u_if.i_alu_rd    = 5'd5;
    u_if.i_alu_dt    = 32'hDEADBEEF;
    #1;
    chk("alu5_ready", {63'd0, u_if.o_alu_ready}, 64'd1);
    push_wr(5'd5, 32'hDEADBEEF);
    cyc();
    u_if.i_alu_valid = 1'b0;
    #1;
    chk("wb5_en", {63'd0, u_if.o_wr_en}, 64'd1);
    chk("busy5_t1", {63'd0, u_if.o_busy_1}, 64'd1);
    cyc();
    chk("busy5_t2", {63'd0, u_if.o_busy_1}, 64'd0);
    chk("sb_err_clean", {63'd0, u_if.o_sb_err}, 64'd0);

    // WAW stall on rd 7; rd 0 always issues
    u_if.i_iss_valid = 1'b1;
    u_if.i_iss_rd    = 5'd7;
    cyc();
    #1;
    chk("iss7_stall", {63'd0, u_if.o_iss_ready}, 64'd0);
    u_if.i_iss_rd = 5'd0;
    #1;
    chk("iss0_ready", {63'd0, u_if.o_iss_ready}, 64'd1);
    cyc();
    u_if.i_iss_valid = 1'b0;
    u_if.i_rd_addr_1 = 5'd7;
    u_if.i_rd_addr_2 = 5'd0;
    #1;
    chk("busy7", {63'd0, u_if.o_busy_1}, 64'd1);
    chk("busy0", {63'd0, u_if.o_busy_2}, 64'd0);

    // LSU result to rd 0: consumed, no write
    u_if.i_lsu_valid = 1'b1;
    u_if.i_lsu_rd    = 5'd0;
    u_if.i_lsu_dt    = 32'hFFFFFFFF;
    #1;
    chk("lsu0_ready", {63'd0, u_if.o_lsu_ready}, 64'd1);
    chk("lsu0_alu_rdy", {63'd0, u_if.o_alu_ready}, 64'd0);
    cyc();
    u_if.i_lsu_valid = 1'b0;
    #1;
    chk("lsu0_no_wr", {63'd0, u_if.o_wr_en}, 64'd0);
    chk("lsu0_busy0", {63'd0, u_if.o_busy_2}, 64'd0);

    // Issue rd 3 and rd 4, then both sources valid together
    u_if.i_iss_valid = 1'b1;
    u_if.i_iss_rd    = 5'd3;
    cyc();
    u_if.i_iss_rd    = 5'd4;
    cyc();
    u_if.i_iss_valid = 1'b0;
    u_if.i_alu_valid = 1'b1;
    u_if.i_alu_rd    = 5'd3;
    u_if.i_alu_dt    = 32'h11;
    u_if.i_lsu_valid = 1'b1;
    u_if.i_lsu_rd    = 5'd4;
    u_if.i_lsu_dt    = 32'h22;
    #1;
    chk("tie1_alu", {63'd0, u_if.o_alu_ready}, 64'd1);
    chk("tie1_lsu", {63'd0, u_if.o_lsu_ready}, 64'd0);
    push_wr(5'd3, 32'h11);
    cyc();
    #1;
    chk("tie2_alu", {63'd0, u_if.o_alu_ready}, 64'd0);
    chk("tie2_lsu", {63'd0, u_if.o_lsu_ready}, 64'd1);
    push_wr(5'd4, 32'h22);
    cyc();
    u_if.i_alu_valid = 1'b0;
    u_if.i_lsu_valid = 1'b0;
    cyc();
    u_if.i_rd_addr_1 = 5'd3;
    u_if.i_rd_addr_2 = 5'd4;
    cyc();
    chk("busy3_clr", {63'd0, u_if.o_busy_1}, 64'd0);
    chk("busy4_clr", {63'd0, u_if.o_busy_2}, 64'd0);
    chk("sb_err_tie", {63'd0, u_if.o_sb_err}, 64'd0);

    // Stray write to non-pending rd 9 raises the sticky error
    u_if.i_alu_valid = 1'b1;
    u_if.i_alu_rd    = 5'd9;
    u_if.i_alu_dt    = 32'h99;
    #1;
    chk("alu9_ready", {63'd0, u_if.o_alu_ready}, 64'd1);
    push_wr(5'd9, 32'h99);
    cyc();
    u_if.i_alu_valid = 1'b0;
    cyc();
    chk("sb_err_set", {63'd0, u_if.o_sb_err}, 64'd1);
    cyc();
    chk("sb_err_sticky", {63'd0, u_if.o_sb_err}, 64'd1);

    // Pend rd 12, put its write in flight, then reset mid-cycle
    u_if.i_iss_valid = 1'b1;
    u_if.i_iss_rd    = 5'd12;
    cyc();
    u_if.i_iss_valid = 1'b0;
    u_if.i_rd_addr_1 = 5'd12;
    u_if.i_alu_valid = 1'b1;
    u_if.i_alu_rd    = 5'd12;
    u_if.i_alu_dt    = 32'hC;
    #1;
    chk("busy12_set", {63'd0, u_if.o_busy_1}, 64'd1);
    cyc();
    u_if.i_alu_valid = 1'b0;
    chk("wb12_inflight", {63'd0, u_if.o_wr_en}, 64'd1);
    rst_async_n = 1'b0;
    #1;
    chk("rst_busy12", {63'd0, u_if.o_busy_1}, 64'd0);
    chk("rst_sb_err2", {63'd0, u_if.o_sb_err}, 64'd0);
    chk("rst_wr_en2", {63'd0, u_if.o_wr_en}, 64'd0);
    cyc();
    rst_async_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_wr_en", {63'd0, u_if.o_wr_en}, 64'd0);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
